combat_resolver: RTL

- Downstream of two `player` instances; consumes each player's FSM state, basic hit box and main hurt box.
- Once per frame tick, decides who got hit and applies damage.
- Maintains per-player health and hitstun counters; raises game-over with a winner.
- Outputs feed the HUD/health-bar renderer and the players' stun inputs.

---
 rtl/fighter_pkg.sv | 29 ++
 rtl/rect_overlap.sv | 17 +
 rtl/combat_resolver.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fighter_pkg.sv
// Shared fighter definitions: player states, box layout, winner codes.
package fighter_pkg;

    localparam int COORD_W = 10;
    localparam int BOX_W   = 4 * COORD_W;

    // Packed box layout is {x1, x2, y1, y2}
    localparam int X1_LSB = 3 * COORD_W;
    localparam int X2_LSB = 2 * COORD_W;
    localparam int Y1_LSB = COORD_W;
    localparam int Y2_LSB = 0;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_FWD      = 4'd1;
    localparam logic [3:0] ST_BACK     = 4'd2;
    localparam logic [3:0] ST_ATK_START = 4'd3;
    localparam logic [3:0] ST_ATK_END  = 4'd4;
    localparam logic [3:0] ST_ATK_PULL = 4'd5;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    function automatic logic [6:0] sub_sat(input logic [6:0] h, input logic [6:0] d);
        return (h < d) ? 7'd0 : h - d;
    endfunction

endpackage

// File: rtl/rect_overlap.sv
// Inclusive axis-aligned rectangle overlap test.
module rect_overlap
    import fighter_pkg::*;
(
    input  logic [BOX_W-1:0] a_box,
    input  logic [BOX_W-1:0] b_box,
    output logic             overlap
);

    always_comb begin
        overlap = (a_box[X1_LSB +: COORD_W] <= b_box[X2_LSB +: COORD_W])
               && (b_box[X1_LSB +: COORD_W] <= a_box[X2_LSB +: COORD_W])
               && (a_box[Y1_LSB +: COORD_W] <= b_box[Y2_LSB +: COORD_W])
               && (b_box[Y1_LSB +: COORD_W] <= a_box[Y2_LSB +: COORD_W]);
    end

endmodule

// File: rtl/combat_resolver.sv
// Per-frame hit resolution: overlap, qualify, then apply damage and stun.
module combat_resolver
    import fighter_pkg::*;
#(
    parameter int         MAX_HEALTH     = 100,
    parameter int         DAMAGE         = 10,
    parameter int         HITSTUN_FRAMES = 20,
    parameter logic [3:0] ACTIVE_STATE   = ST_ATK_END
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic [3:0]       p1_state,
    input  logic [3:0]       p2_state,
    input  logic [BOX_W-1:0] p1_hit_box,
    input  logic [BOX_W-1:0] p2_hit_box,
    input  logic [BOX_W-1:0] p1_hurt_box,
    input  logic [BOX_W-1:0] p2_hurt_box,
    output logic [6:0]       p1_health,
    output logic [6:0]       p2_health,
    output logic             p1_stunned,
    output logic             p2_stunned,
    output logic             p1_hit_pulse,
    output logic             p2_hit_pulse,
    output logic             game_over,
    output logic [1:0]       winner
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SAMPLE = 2'd1;
    localparam logic [1:0] S_EVAL   = 2'd2;
    localparam logic [1:0] S_APPLY  = 2'd3;

    localparam logic [6:0] MAX_H = 7'(MAX_HEALTH);
    localparam logic [6:0] DMG   = 7'(DAMAGE);
    localparam logic [4:0] STUN  = 5'(HITSTUN_FRAMES);

    logic [1:0]       fsm_q, fsm_d;
    logic [3:0]       st1_q, st1_d, st2_q, st2_d;
    logic [BOX_W-1:0] hit1_q, hit1_d, hit2_q, hit2_d;
    logic [BOX_W-1:0] hurt1_q, hurt1_d, hurt2_q, hurt2_d;
    logic             ov12_q, ov12_d, ov21_q, ov21_d;
    logic             q12_q, q12_d, q21_q, q21_d;
    logic             latch1_q, latch1_d, latch2_q, latch2_d;
    logic [6:0]       h1_q, h1_d, h2_q, h2_d;
    logic [4:0]       stun1_q, stun1_d, stun2_q, stun2_d;
    logic             pulse1_q, pulse1_d, pulse2_q, pulse2_d;
    logic             go_q, go_d;
    logic [1:0]       win_q, win_d;
    logic             ov12, ov21;
    logic [6:0]       nh1, nh2;

    rect_overlap u_ov12 (.a_box(hit1_q), .b_box(hurt2_q), .overlap(ov12));
    rect_overlap u_ov21 (.a_box(hit2_q), .b_box(hurt1_q), .overlap(ov21));

    always_comb begin
        fsm_d    = fsm_q;
        st1_d    = st1_q;
        st2_d    = st2_q;
        hit1_d   = hit1_q;
        hit2_d   = hit2_q;
        hurt1_d  = hurt1_q;
        hurt2_d  = hurt2_q;
        ov12_d   = ov12_q;
        ov21_d   = ov21_q;
        q12_d    = q12_q;
        q21_d    = q21_q;
        latch1_d = latch1_q;
        latch2_d = latch2_q;
        h1_d     = h1_q;
        h2_d     = h2_q;
        stun1_d  = stun1_q;
        stun2_d  = stun2_q;
        pulse1_d = 1'b0;
        pulse2_d = 1'b0;
        go_d     = go_q;
        win_d    = win_q;
        nh1      = h1_q;
        nh2      = h2_q;
        unique case (fsm_q)
            S_IDLE: begin
                if (frame_tick) begin
                    st1_d   = p1_state;
                    st2_d   = p2_state;
                    hit1_d  = p1_hit_box;
                    hit2_d  = p2_hit_box;
                    hurt1_d = p1_hurt_box;
                    hurt2_d = p2_hurt_box;
                    fsm_d   = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                ov12_d = ov12;
                ov21_d = ov21;
                fsm_d  = S_EVAL;
            end
            S_EVAL: begin
                q12_d = (st1_q == ACTIVE_STATE) && ov12_q && !latch1_q
                     && (stun2_q == 5'd0) && !go_q;
                q21_d = (st2_q == ACTIVE_STATE) && ov21_q && !latch2_q
                     && (stun1_q == 5'd0) && !go_q;
                // Latch holds for the whole swing so one attack lands once
                latch1_d = (st1_q == ACTIVE_STATE) && (latch1_q || q12_d);
                latch2_d = (st2_q == ACTIVE_STATE) && (latch2_q || q21_d);
                fsm_d = S_APPLY;
            end
            default: begin
                stun1_d = q21_q ? STUN : (stun1_q != 5'd0 ? stun1_q - 5'd1 : 5'd0);
                stun2_d = q12_q ? STUN : (stun2_q != 5'd0 ? stun2_q - 5'd1 : 5'd0);
                if (!go_q) begin
                    nh1      = q21_q ? sub_sat(h1_q, DMG) : h1_q;
                    nh2      = q12_q ? sub_sat(h2_q, DMG) : h2_q;
                    h1_d     = nh1;
                    h2_d     = nh2;
                    pulse1_d = q12_q;
                    pulse2_d = q21_q;
                    if (nh1 == 7'd0 || nh2 == 7'd0) begin
                        go_d  = 1'b1;
                        win_d = (nh1 == 7'd0 && nh2 == 7'd0) ? WIN_DRAW :
                                (nh2 == 7'd0) ? WIN_P1 : WIN_P2;
                    end
                end
                fsm_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q    <= S_IDLE;
            st1_q    <= '0;
            st2_q    <= '0;
            hit1_q   <= '0;
            hit2_q   <= '0;
            hurt1_q  <= '0;
            hurt2_q  <= '0;
            ov12_q   <= 1'b0;
            ov21_q   <= 1'b0;
            q12_q    <= 1'b0;
            q21_q    <= 1'b0;
            latch1_q <= 1'b0;
            latch2_q <= 1'b0;
            h1_q     <= MAX_H;
            h2_q     <= MAX_H;
            stun1_q  <= '0;
            stun2_q  <= '0;
            pulse1_q <= 1'b0;
            pulse2_q <= 1'b0;
            go_q     <= 1'b0;
            win_q    <= WIN_NONE;
        end else begin
            fsm_q    <= fsm_d;
            st1_q    <= st1_d;
            st2_q    <= st2_d;
            hit1_q   <= hit1_d;
            hit2_q   <= hit2_d;
            hurt1_q  <= hurt1_d;
            hurt2_q  <= hurt2_d;
            ov12_q   <= ov12_d;
            ov21_q   <= ov21_d;
            q12_q    <= q12_d;
            q21_q    <= q21_d;
            latch1_q <= latch1_d;
            latch2_q <= latch2_d;
            h1_q     <= h1_d;
            h2_q     <= h2_d;
            stun1_q  <= stun1_d;
            stun2_q  <= stun2_d;
            pulse1_q <= pulse1_d;
            pulse2_q <= pulse2_d;
            go_q     <= go_d;
            win_q    <= win_d;
        end
    end

    assign p1_health    = h1_q;
    assign p2_health    = h2_q;
    assign p1_stunned   = (stun1_q != 5'd0);
    assign p2_stunned   = (stun2_q != 5'd0);
    assign p1_hit_pulse = pulse1_q;
    assign p2_hit_pulse = pulse2_q;
    assign game_over    = go_q;
    assign winner       = win_q;

endmodule
